// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display path (binary-to-BCD
// encoder and the seven-segment drivers that consume its digits).
package score_display_pkg;

  // Encoder control states: waiting for a request, or iterating the
  // shift-and-add-3 loop.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A BCD nibble at or above this value would exceed 9 after the next
  // doubling, so it is pre-corrected by adding 3.
  localparam int BCD_ADD3_THRESHOLD = 5;

  // Digit value shown on every position when the score cannot be represented.
  localparam logic [3:0] BCD_NINE = 4'h9;

  // Number of HEX digits on the board display.
  localparam int DEFAULT_DIGITS = 4;

endpackage : score_display_pkg

// File: rtl/bcd_add3.sv
// Combinational nibble corrector used by the double-dabble iteration.
// Inputs of 5..9 become 8..12.
// Inputs of 10..15 never reach this block from a valid BCD scratch register.
// The 4-bit add still wraps cleanly for those values and carries nothing
// into the neighbouring digit.
module bcd_add3
  import score_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [3:0] nibble_o
);

  // Add 3 when the digit would overflow past 9 after the following shift.
  always_comb begin
    nibble_o = nibble_i;
    if (nibble_i >= 4'(BCD_ADD3_THRESHOLD)) begin
      nibble_o = nibble_i + 4'd3;
    end
  end

endmodule : bcd_add3

// File: rtl/score_bcd_encoder.sv
// Sequential binary-to-BCD encoder for the snake game score.
// One conversion takes BIN_W clock cycles.
// Results are registered on the done edge and held until the next one.
// The HEX display therefore never shows intermediate values.
module score_bcd_encoder
  import score_display_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(1);
  localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [SCR_W-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [SCR_W-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [SCR_W-1:0]    corrected;
  logic [SCR_W-1:0]    shiftedScratch;
  logic [BIN_W-1:0]    shiftedBin;
  logic                carryOut;
  logic                stickyOvf;
  logic [SCR_W-1:0]    finalDigits;
  logic [DIGITS-1:0]   finalBlank;
  logic                leadingZero;

  // One add-3 corrector per digit of the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
    bcd_add3 u_add3 (
      .nibble_i (scratch_q[4*g +: 4]),
      .nibble_o (corrected[4*g +: 4])
    );
  end

  // One double-dabble step: the corrected scratch and the binary register
  // shift left as a single long register.
  // The bit leaving the top digit means the value is too large for DIGITS
  // digits.
  always_comb begin
    carryOut       = corrected[SCR_W-1];
    shiftedScratch = {corrected[SCR_W-2:0], bin_q[BIN_W-1]};
    shiftedBin     = bin_q << 1;
    stickyOvf      = ovf_q | carryOut;
    finalDigits    = stickyOvf ? {DIGITS{BCD_NINE}} : shiftedScratch;
  end

  // Leading-zero mask for the result about to be published.
  // A digit is blanked only when it and every more-significant digit are zero.
  // Digit 0 is never blanked, so a zero score still shows "0".
  always_comb begin
    finalBlank  = '0;
    leadingZero = 1'b1;
    if (!stickyOvf) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        leadingZero   = leadingZero & (finalDigits[4*i +: 4] == 4'd0);
        finalBlank[i] = leadingZero;
      end
    end
  end

  // Next-state logic for the control FSM, the working registers and the
  // held outputs.
  // Outputs hold by default and are loaded only on the final iteration.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = CNT_LOAD;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        scratch_d = shiftedScratch;
        bin_d     = shiftedBin;
        ovf_d     = stickyOvf;
        cnt_d     = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          bcd_d      = finalDigits;
          blank_d    = finalBlank;
          overflow_d = stickyOvf;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers.
  // Reset abandons any conversion in flight and restores the blank "0" display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= BLANK_RESET;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign blank    = blank_q;
  assign overflow = overflow_q;

endmodule : score_bcd_encoder
